// File: rtl/ctx_arb_pkg.sv
// Shared state encoding and default sizing for the context read arbiter.
package ctx_arb_pkg;

    localparam int NREQ_DFLT = 4;
    localparam int DW_DFLT   = 16;
    localparam int TMO_DFLT  = 15;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

endpackage

// File: rtl/ctx_read_arbiter_rr_picker.sv
// Round-robin pick: first requester at or above ptr, searching upward with wrap.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_picker #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic            vld
);

    always_comb begin
        int idx;
        logic [PW-1:0] idx_b;
        idx   = 0;
        idx_b = '0;
        win   = '0;
        vld   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            idx_b = PW'(idx);
            if (!vld && req[idx_b]) begin
                win[idx_b] = 1'b1;
                vld        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ctx_read_arbiter.sv
// Arbitrates requester reads of one local context register and returns the value.
// Latency: gnt/rd_en one cycle after req is sampled in IDLE, rsp_valid three cycles after.
// Backpressure: response held until ack from the granted requester or TMO cycles elapse.
module ctx_read_arbiter
    import ctx_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DFLT,
    parameter int DW   = DW_DFLT,
    parameter int TMO  = TMO_DFLT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] ack,
    input  logic [DW-1:0]   ctx_in,
    output logic            rd_en,
    output logic [NREQ-1:0] gnt,
    output logic            rsp_valid,
    output logic [DW-1:0]   rsp_data,
    output logic            timeout_err,
    output logic            busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [DW-1:0]   rsp_data_q, rsp_data_d;
    logic            rd_en_q, rd_en_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            timeout_err_q, timeout_err_d;
    logic            busy_q, busy_d;

    logic [NREQ-1:0] win;
    logic            win_vld;
    logic [PW-1:0]   gidx, gidx_nxt;
    logic            ack_hit, expire;

    rr_picker #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req (req),
        .ptr (ptr_q),
        .win (win),
        .vld (win_vld)
    );

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) gidx = PW'(i);
        end
        gidx_nxt = (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);
    end

    // Ack beats expiry when both land in the same RESP cycle.
    assign ack_hit = (state_q == RESP) && |(ack & gnt_q);
    assign expire  = (state_q == RESP) && !ack_hit && (cnt_q == 8'(TMO - 1));

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        gnt_d      = gnt_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    gnt_d   = win;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = CAPTURE;
            CAPTURE: begin
                rsp_data_d = ctx_in;
                cnt_d      = '0;
                state_d    = RESP;
            end
            RESP: begin
                if (ack_hit || expire) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = gidx_nxt;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Outputs are registered copies of what the next state implies.
        rd_en_d       = (state_d == ISSUE);
        rsp_valid_d   = (state_d == RESP);
        busy_d        = (state_d != IDLE);
        timeout_err_d = expire;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            cnt_q         <= '0;
            gnt_q         <= '0;
            rsp_data_q    <= '0;
            rd_en_q       <= 1'b0;
            rsp_valid_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            gnt_q         <= gnt_d;
            rsp_data_q    <= rsp_data_d;
            rd_en_q       <= rd_en_d;
            rsp_valid_q   <= rsp_valid_d;
            timeout_err_q <= timeout_err_d;
            busy_q        <= busy_d;
        end
    end

    assign rd_en       = rd_en_q;
    assign gnt         = gnt_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign timeout_err = timeout_err_q;
    assign busy        = busy_q;

endmodule

// File: doc/ctx_read_arbiter.md
CTX_READ_ARBITER -- requirements
Module: ctx_read_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the local context register.
REQ-002 Parameter DW, default 16: context data width.
REQ-003 Parameter TMO, default 15: maximum cycles a response waits for ack, range 1..255.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 req  in  NREQ  per-requester read request, level-sensitive.
REQ-007 ack  in  NREQ  per-requester response acceptance.
REQ-008 ctx_in  in  DW  context value returned by the local context register.
REQ-009 rd_en  out  1  read enable to the local context register.
REQ-010 gnt  out  NREQ  one-hot grant, registered.
REQ-011 rsp_valid  out  1  rsp_data valid for the granted requester.
REQ-012 rsp_data  out  DW  captured context value.
REQ-013 timeout_err  out  1  single-cycle pulse on response timeout.
REQ-014 busy  out  1  high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have four states: IDLE, ISSUE, CAPTURE and RESP.
REQ-016 IDLE: if any req bit is high, the arbiter SHALL select the winner round-robin, starting at ptr and searching upward with wrap, set gnt to that winner, and go to ISSUE; otherwise it stays in IDLE.
REQ-017 ISSUE SHALL last exactly one cycle, drive rd_en=1 (the only cycle rd_en is high), and go to CAPTURE.
REQ-018 CAPTURE SHALL last exactly one cycle, load rsp_data <= ctx_in, and go to RESP.
REQ-019 RESP SHALL drive rsp_valid=1 and hold gnt and rsp_data stable until completion.
REQ-020 Latency: a req first sampled high in IDLE at edge n SHALL produce gnt at n+1, rd_en during cycle n+1, and rsp_valid at n+3.
REQ-021 Completion by ack: ack[g]=1 in RESP, where g is the granted index, SHALL return the FSM to IDLE next edge, clear gnt and rsp_valid, and set ptr <= (g+1) mod NREQ.
REQ-022 ack bits of non-granted requesters, and any ack outside RESP, SHALL be ignored.
REQ-023 A timeout counter (8 bits) SHALL clear on entry to RESP and increment each RESP cycle without ack[g].
REQ-024 Timeout: when the counter reaches TMO-1 without ack[g], the arbiter SHALL pulse timeout_err for one cycle, return to IDLE, and advance ptr as for an ack.
REQ-025 When ack[g] and timeout expiry occur in the same cycle, ack SHALL win: no timeout_err.
REQ-026 Dropping req[g] after grant SHALL NOT abort the transaction; it ends only by ack or timeout.
REQ-027 A requester holding req high continuously SHALL be re-granted no sooner than after every other active requester has been served once (starvation-free).
REQ-028 Back-to-back operation: at most one IDLE cycle SHALL separate consecutive transactions.

Reset
REQ-029 While rst=0: state=IDLE, ptr=0, timeout counter=0, gnt=0, rd_en=0, rsp_valid=0, rsp_data=0, timeout_err=0, busy=0, asynchronously.
REQ-030 Reset mid-transaction SHALL abandon the transaction without any timeout_err pulse.
REQ-031 After rst rises, the first arbitration SHALL start from requester 0.

Structure
REQ-032 Shared package ctx_arb_pkg SHALL hold the state enum (IDLE, ISSUE, CAPTURE, RESP) and the default constants NREQ, DW and TMO.
REQ-033 Round-robin selection SHALL be a combinational sub-module rr_picker, with inputs req and ptr and outputs one-hot winner and valid.
REQ-034 All outputs SHALL be driven directly from flops.

Verification
REQ-035 Single request: req=4'b0010, ctx_in=16'h0001 -> gnt=4'b0010 at n+1; rd_en for 1 cycle; rsp_valid with rsp_data=16'h0001 at n+3; ack[1] -> IDLE, ptr=2.
REQ-036 Contention: req=4'b1111 held, ack given on the first rsp_valid cycle -> grant order 0,1,2,3,0, with one IDLE cycle between transactions.
REQ-037 Timeout: req=4'b0100, ack never given -> timeout_err pulses exactly once, 15 cycles after rsp_valid rises; ptr=3; gnt cleared.
REQ-038 Ack collision: ack[2] asserted in the expiry cycle (TMO=15) -> no timeout_err; wrong-index ack[0] during RESP -> ignored.
REQ-039 Reset in CAPTURE: rst=0 -> all outputs 0 immediately; after release with req=4'b1000 -> grant goes to requester 3, and ptr search restarts from 0.
